// File: rtl/intdiv_sched.sv
// Round-robin scheduler sharing one fixed-latency pipelined signed divider among NREQ requesters,
// with credit-protected in-order response FIFO. Optional divide-by-zero bypass: INTDIV_DIV0_CHECK_EN.
module intdiv_sched #(
  parameter int N         = 9,
  parameter int NREQ      = 4,
  parameter int IDW       = 2,
  parameter int LAT       = 5,
  parameter int RSP_DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*N-1:0]   req_x,
  input  logic [NREQ*N-1:0]   req_y,
  output logic [N-1:0]        div_x,
  output logic [N-1:0]        div_y,
  input  logic [N-1:0]        div_z,
  input  logic [N-1:0]        div_r,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [N-1:0]        rsp_z,
  output logic [N-1:0]        rsp_r
`ifdef INTDIV_DIV0_CHECK_EN
  ,
  output logic                rsp_div0
`endif
);

  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [IDW-1:0] id;
`ifdef INTDIV_DIV0_CHECK_EN
    logic           div0;
    logic [N-1:0]   x;
`endif
  } tag_t;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [N-1:0]   z;
    logic [N-1:0]   r;
`ifdef INTDIV_DIV0_CHECK_EN
    logic           div0;
`endif
  } rsp_t;

  logic [IDW-1:0] rr_ptr;
  logic           gnt_any;
  logic [IDW-1:0] gnt_id;
  logic [IDW-1:0] idx;
  logic [N-1:0]   sel_x, sel_y;
  logic [CW-1:0]  fifo_cnt, inflight;
  logic [CW:0]    used;
  logic           credit_ok;
  logic [LAT:0]   vld_pipe;
  tag_t           tag_pipe [LAT:0];
  tag_t           new_tag;
  logic           retire, pop;
  rsp_t           wdata;
  rsp_t           mem [RSP_DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;

  // Credit covers both buffered and in-flight results, so retire never meets a full FIFO.
  assign used      = {1'b0, fifo_cnt} + {1'b0, inflight};
  assign credit_ok = used < (CW+1)'(RSP_DEPTH);

  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    if (!reset && credit_ok) begin
      for (int i = 0; i < NREQ; i++) begin
        idx = IDW'((int'(rr_ptr) + i) % NREQ);
        if (!gnt_any && req_valid[idx]) begin
          gnt_any = 1'b1;
          gnt_id  = idx;
        end
      end
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_rdy
    assign req_ready[i] = gnt_any && (gnt_id == IDW'(i));
  end

  assign sel_x = req_x[int'(gnt_id)*N +: N];
  assign sel_y = req_y[int'(gnt_id)*N +: N];

  always_comb begin
    new_tag    = '0;
    new_tag.id = gnt_id;
    div_x      = '0;
    div_y      = '0;
`ifdef INTDIV_DIV0_CHECK_EN
    new_tag.div0 = gnt_any && (sel_y == '0);
    new_tag.x    = sel_x;
    if (gnt_any && !new_tag.div0) begin
      div_x = sel_x;
      div_y = sel_y;
    end
`else
    if (gnt_any) begin
      div_x = sel_x;
      div_y = sel_y;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) rr_ptr <= '0;
    else if (gnt_any) rr_ptr <= IDW'((int'(gnt_id) + 1) % NREQ);
  end

  // Stage LAT lines up with the cycle the divider presents the matching result.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_pipe <= '0;
      for (int s = 0; s <= LAT; s++) tag_pipe[s] <= '0;
    end else begin
      vld_pipe    <= {vld_pipe[LAT-1:0], gnt_any};
      tag_pipe[0] <= new_tag;
      for (int s = 1; s <= LAT; s++) tag_pipe[s] <= tag_pipe[s-1];
    end
  end

  assign retire    = vld_pipe[LAT];
  assign rsp_valid = (fifo_cnt != '0);
  assign pop       = rsp_valid && rsp_ready;

  always_comb begin
    wdata    = '0;
    wdata.id = tag_pipe[LAT].id;
    wdata.z  = div_z;
    wdata.r  = div_r;
`ifdef INTDIV_DIV0_CHECK_EN
    if (tag_pipe[LAT].div0) begin
      wdata.z    = '1;
      wdata.r    = tag_pipe[LAT].x;
      wdata.div0 = 1'b1;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      inflight <= '0;
    end else begin
      case ({gnt_any, retire})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (retire) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({retire, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign rsp_id = mem[rd_ptr].id;
  assign rsp_z  = mem[rd_ptr].z;
  assign rsp_r  = mem[rd_ptr].r;
`ifdef INTDIV_DIV0_CHECK_EN
  assign rsp_div0 = mem[rd_ptr].div0;
`endif

endmodule
